vga_draw_arbiter: RTL
=====================

# vga_draw_arbiter

Round-robin arbiter that shares the single VGA adapter plot port (x, y, colour, plot) among the game's drawing engines: border, ball, second ball, bottom paddle, top paddle and full-screen erase. Each engine raises a request, receives an exclusive one-hot grant, streams pixels and signals done. The arbiter registers the granted engine's pixel stream onto the adapter inputs. A watchdog forces release of an engine that never finishes. It replaces the priority if/else pixel mux and OR-ed write enables in the game controller.

## Interface
- NUM_REQ, 6, number of requesters (2..8); index 0 = border, 1 = ball, 2 = ball_1, 3 = paddle, 4 = paddle_top, 5 = erase
- TIMEOUT_CYCLES, 20000, max grant length in cycles before forced release; 0 disables the watchdog; must be < 2^24

- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester draw request, level
- done  in  NUM_REQ  per-requester end-of-draw, one-cycle pulse
- plot_in  in  NUM_REQ  per-requester pixel write enable
- x_in  in  8*NUM_REQ  packed x; requester i at [8i+7:8i]
- y_in  in  7*NUM_REQ  packed y; requester i at [7i+6:7i]
- colour_in  in  3*NUM_REQ  packed colour; requester i at [3i+2:3i]
- grant  out  NUM_REQ  one-hot grant, registered
- x_out  out  8  to VGA adapter x
- y_out  out  7  to VGA adapter y
- colour_out  out  3  to VGA adapter colour
- plot  out  1  to VGA adapter plot
- busy  out  1  high while in GRANT or RELEASE
- active_id  out  3  index of the current or last granted requester
- timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: if any req bit is high, select a winner and go to GRANT. Otherwise stay in IDLE.
- Winner selection: search upward from (last+1) mod NUM_REQ, wrapping, and take the first req bit that is high. `last` resets to NUM_REQ-1, so requester 0 wins first after reset.
- GRANT: grant[w] = 1 and active_id = w. The watchdog counter (24 bit) increments every cycle, starting from 0 on entry.
- Exit from GRANT to RELEASE on any of:
  - done[w] = 1 (normal completion),
  - req[w] = 0 (abort),
  - counter == TIMEOUT_CYCLES - 1 with TIMEOUT_CYCLES != 0 (forced release).
- If both done[w] and the watchdog fire in the same cycle, done wins and timeout stays 0.
- On the transition to RELEASE:
  - grant clears,
  - `last` is set to w,
  - timeout pulses for one cycle only on a forced release.
- RELEASE always goes to IDLE on the next edge.
- done, plot_in and req from non-granted requesters are ignored.
- Pixel path:
  - Each cycle in GRANT, x_out, y_out and colour_out are registered from slice w, and plot is registered as plot_in[w].
  - A pixel presented together with done[w] is still plotted.
  - In IDLE and RELEASE, plot = 0 and x_out, y_out, colour_out hold their last values.
- Reset values: state IDLE, grant 0, plot 0, x_out 0, y_out 0, colour_out 0, busy 0, active_id 0, timeout 0, counter 0, `last` NUM_REQ-1.
- Reset mid-grant: everything returns to reset values on the next edge, and no pixel is written in that cycle.

## Timing
- Request to grant: req[i] first high at edge n while in IDLE, grant[i] high after edge n+1.
- Pixel latency: plot_in[w] in cycle k appears on plot in cycle k+1 (one register stage). Requesters need no backpressure.
- Release:
  - done[w] in cycle k;
  - grant low and state RELEASE after edge k+1;
  - IDLE after edge k+2;
  - next grant, if req is pending, after edge k+3.
  - The gap between grants is 2 cycles with no grant.
- Watchdog: a grant lasts at most TIMEOUT_CYCLES cycles.
- busy goes high on the same edge as grant and falls on entry to IDLE.

## Test plan
- Single requester: after reset, raise req[5] and give 5 plot_in pulses with x = 10..14, y = 3, colour = 7, then done. Required: grant = 6'b100000 one cycle after req; 5 plot pulses, each one cycle after its input, with matching x/y/colour; grant low the cycle after done.
- Round-robin: hold req = 6'b111111 and give each grantee done 3 cycles after its grant. Required grant order: 0,1,2,3,4,5,0; exactly 2 idle cycles between grants; grant always one-hot.
- Isolation: req[1] and req[3] high; only 1 is granted. Pulse plot_in[3] and done[3] during grant 1. Required: no plot output and no release; grant 1 persists until done[1].
- Watchdog: TIMEOUT_CYCLES = 50, req[2] held with no done. Required: grant[2] high for exactly 50 cycles; timeout = 1 for one cycle at release; next grant goes to requester 3 if pending, otherwise to 2 again.
- Abort and reset: drop req[4] mid-grant. Required: release next edge with timeout = 0. Then assert reset mid-grant of requester 0. Required: next edge gives grant = 0, plot = 0, x/y/colour = 0; after reset, requester 0 wins first.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the VGA adapter plot port among the drawing engines.
// The granted engine's pixel stream is registered onto the adapter; a watchdog forces release.
module vga_draw_arbiter #(
  parameter int NUM_REQ        = 6,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  input  logic [NUM_REQ-1:0]   plot_in,
  input  logic [8*NUM_REQ-1:0] x_in,
  input  logic [7*NUM_REQ-1:0] y_in,
  input  logic [3*NUM_REQ-1:0] colour_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           x_out,
  output logic [6:0]           y_out,
  output logic [2:0]           colour_out,
  output logic                 plot,
  output logic                 busy,
  output logic [2:0]           active_id,
  output logic                 timeout,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [23:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 24'd0 : 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]     id_q, id_d;
  logic [IW-1:0]     last_q, last_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        col_q, col_d;
  logic              plot_q, plot_d;
  logic              timeout_q, timeout_d;

  logic [7:0] x_arr   [NUM_REQ];
  logic [6:0] y_arr   [NUM_REQ];
  logic [2:0] col_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g]   = x_in[8*g +: 8];
    assign y_arr[g]   = y_in[7*g +: 7];
    assign col_arr[g] = colour_in[3*g +: 3];
  end

  // Round-robin search starts just above the last released requester.
  logic          win_found;
  logic [IW-1:0] win_id;
  int            cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && req[IW'(cand)]) begin
        win_found = 1'b1;
        win_id    = IW'(cand);
      end
    end
  end

  logic wd_fire;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = '0;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    plot_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d         = S_GRANT;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          id_d            = win_id;
        end
      end
      S_GRANT: begin
        cnt_d  = cnt_q + 24'd1;
        x_d    = x_arr[id_q];
        y_d    = y_arr[id_q];
        col_d  = col_arr[id_q];
        plot_d = plot_in[id_q];
        if (done[id_q] || !req[id_q] || wd_fire) begin
          state_d   = S_RELEASE;
          grant_d   = '0;
          last_d    = id_q;
          // A normal completion in the same cycle as the watchdog is not a forced release.
          timeout_d = wd_fire && !done[id_q];
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      plot_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      plot_q    <= plot_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant      = grant_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign plot       = plot_q;
  assign busy       = (state_q != S_IDLE);
  assign active_id  = 3'(id_q);
  assign timeout    = timeout_q;
  assign state_dbg  = state_q;

endmodule
